// File: rtl/zigzag_run_expander.sv
`default_nettype none
// ============================================================================
// Module      : zigzag_run_expander
// Description : Expands (run, level, EOB) tokens into 64 coefficients per
//               8x8 block, emitted in zigzag order. Each coefficient carries
//               its raster row/col. One registered output slot with a
//               valid/ready handshake on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module zigzag_run_expander #(
  parameter int PIXEL_BIT = 12,
  parameter int BLOCK_BIT = 3,
  parameter int RUN_BIT   = 4
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [RUN_BIT-1:0]   rle_run_i,
  input  logic [PIXEL_BIT-1:0] rle_level_i,
  input  logic                 rle_eob_i,
  input  logic                 rle_gecerli_i,
  output logic                 rle_hazir_o,
  output logic [PIXEL_BIT-1:0] zig_veri_o,
  output logic [BLOCK_BIT-1:0] zig_veri_row_o,
  output logic [BLOCK_BIT-1:0] zig_veri_col_o,
  output logic                 zig_veri_gecerli_o,
  input  logic                 zig_veri_hazir_i,
  output logic                 zig_blok_son_o,
  output logic                 hata_o
);

  localparam int c_IDX_W = 2 * BLOCK_BIT;
  // One spare bit so idx+run cannot wrap; its MSB flags a run past idx 63.
  localparam int c_SUM_W = c_IDX_W + 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = {c_IDX_W{1'b1}};

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_RUN    = 2'd1,
    ST_FILL   = 2'd2
  } state_t;

  // Zigzag index -> raster position {row, col}, standard JPEG order.
  function automatic logic [c_IDX_W-1:0] zz_raster(input logic [c_IDX_W-1:0] zz);
    logic [c_IDX_W-1:0] p;
    case (zz)
      6'd0 : p = 6'd0;   6'd1 : p = 6'd1;   6'd2 : p = 6'd8;   6'd3 : p = 6'd16;
      6'd4 : p = 6'd9;   6'd5 : p = 6'd2;   6'd6 : p = 6'd3;   6'd7 : p = 6'd10;
      6'd8 : p = 6'd17;  6'd9 : p = 6'd24;  6'd10: p = 6'd32;  6'd11: p = 6'd25;
      6'd12: p = 6'd18;  6'd13: p = 6'd11;  6'd14: p = 6'd4;   6'd15: p = 6'd5;
      6'd16: p = 6'd12;  6'd17: p = 6'd19;  6'd18: p = 6'd26;  6'd19: p = 6'd33;
      6'd20: p = 6'd40;  6'd21: p = 6'd48;  6'd22: p = 6'd41;  6'd23: p = 6'd34;
      6'd24: p = 6'd27;  6'd25: p = 6'd20;  6'd26: p = 6'd13;  6'd27: p = 6'd6;
      6'd28: p = 6'd7;   6'd29: p = 6'd14;  6'd30: p = 6'd21;  6'd31: p = 6'd28;
      6'd32: p = 6'd35;  6'd33: p = 6'd42;  6'd34: p = 6'd49;  6'd35: p = 6'd56;
      6'd36: p = 6'd57;  6'd37: p = 6'd50;  6'd38: p = 6'd43;  6'd39: p = 6'd36;
      6'd40: p = 6'd29;  6'd41: p = 6'd22;  6'd42: p = 6'd15;  6'd43: p = 6'd23;
      6'd44: p = 6'd30;  6'd45: p = 6'd37;  6'd46: p = 6'd44;  6'd47: p = 6'd51;
      6'd48: p = 6'd58;  6'd49: p = 6'd59;  6'd50: p = 6'd52;  6'd51: p = 6'd45;
      6'd52: p = 6'd38;  6'd53: p = 6'd31;  6'd54: p = 6'd39;  6'd55: p = 6'd46;
      6'd56: p = 6'd53;  6'd57: p = 6'd60;  6'd58: p = 6'd61;  6'd59: p = 6'd54;
      6'd60: p = 6'd47;  6'd61: p = 6'd55;  6'd62: p = 6'd62;  6'd63: p = 6'd63;
      default: p = '0;
    endcase
    return p;
  endfunction

  state_t               r_state;
  state_t               w_state_next;
  logic [c_IDX_W-1:0]   r_idx;
  logic [RUN_BIT-1:0]   r_rem;
  logic [RUN_BIT-1:0]   w_rem_next;
  logic [PIXEL_BIT-1:0] r_level;
  logic                 r_hata;
  logic [PIXEL_BIT-1:0] r_data;
  logic [BLOCK_BIT-1:0] r_row;
  logic [BLOCK_BIT-1:0] r_col;
  logic                 r_valid;
  logic                 r_son;

  logic                 w_slot_free;
  logic                 w_tok_fire;
  logic                 w_load;
  logic [PIXEL_BIT-1:0] w_load_data;
  logic                 w_level_we;
  logic                 w_set_hata;
  logic [c_SUM_W-1:0]   w_sum;
  logic                 w_overflow;
  logic [c_IDX_W-1:0]   w_pos;

  // The slot may be reloaded whenever it is empty or being drained this cycle.
  assign w_slot_free = !r_valid || zig_veri_hazir_i;
  // Ready is forced low while reset is held so nothing is taken during reset.
  assign rle_hazir_o = rstn_i && (r_state == ST_ACCEPT) && w_slot_free;
  assign w_tok_fire  = rle_gecerli_i && rle_hazir_o;

  assign w_sum      = {1'b0, r_idx} + {{(c_SUM_W-RUN_BIT){1'b0}}, rle_run_i};
  assign w_overflow = w_sum[c_SUM_W-1];
  assign w_pos      = zz_raster(r_idx);

  assign zig_veri_o         = r_data;
  assign zig_veri_row_o     = r_row;
  assign zig_veri_col_o     = r_col;
  assign zig_veri_gecerli_o = r_valid;
  assign zig_blok_son_o     = r_son;
  assign hata_o             = r_hata;

  // Next-state and slot-load decisions.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_load_data  = '0;
    w_rem_next   = r_rem;
    w_level_we   = 1'b0;
    w_set_hata   = 1'b0;
    case (r_state)
      ST_ACCEPT: begin
        if (w_tok_fire) begin
          w_load = 1'b1;
          if (rle_eob_i) begin
            if (r_idx != c_LAST_IDX) w_state_next = ST_FILL;
          end else if (rle_run_i == '0) begin
            w_load_data = rle_level_i;
          end else if (w_overflow) begin
            // Run overshoots the block: pad with zeros to the end, drop level.
            w_set_hata = 1'b1;
            if (r_idx != c_LAST_IDX) w_state_next = ST_FILL;
          end else begin
            w_level_we   = 1'b1;
            w_rem_next   = rle_run_i - RUN_BIT'(1);
            w_state_next = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (w_slot_free) begin
          w_load = 1'b1;
          if (r_rem == '0) begin
            w_load_data  = r_level;
            w_state_next = ST_ACCEPT;
          end else begin
            w_rem_next = r_rem - RUN_BIT'(1);
          end
        end
      end
      ST_FILL: begin
        if (w_slot_free) begin
          w_load = 1'b1;
          if (r_idx == c_LAST_IDX) w_state_next = ST_ACCEPT;
        end
      end
      default: w_state_next = ST_ACCEPT;
    endcase
  end

  // State, run counter, latched level and sticky error.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state <= ST_ACCEPT;
      r_rem   <= '0;
      r_level <= '0;
      r_hata  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_rem   <= w_rem_next;
      if (w_level_we) r_level <= rle_level_i;
      if (w_set_hata) r_hata  <= 1'b1;
    end
  end

  // Output slot and zigzag index; each load stamps LUT row/col and advances idx.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_idx   <= '0;
      r_data  <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_valid <= 1'b0;
      r_son   <= 1'b0;
    end else if (w_load) begin
      r_data  <= w_load_data;
      r_row   <= w_pos[c_IDX_W-1:BLOCK_BIT];
      r_col   <= w_pos[BLOCK_BIT-1:0];
      r_son   <= (r_idx == c_LAST_IDX);
      r_valid <= 1'b1;
      r_idx   <= r_idx + c_IDX_W'(1);
    end else if (zig_veri_hazir_i) begin
      r_valid <= 1'b0;
      r_son   <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_zigzag_run_expander.sv
`default_nettype none
// ============================================================================
// Module      : tb_zigzag_run_expander
// Description : Scoreboard bench for zigzag_run_expander. A token-level model
//               pushes expected beats on acceptance; a monitor pops and
//               compares them on every output transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zigzag_run_expander;

  localparam int PIXEL_BIT = 12;
  localparam int BLOCK_BIT = 3;
  localparam int RUN_BIT   = 4;

  logic                 clk_i = 1'b0;
  logic                 rstn_i;
  logic [RUN_BIT-1:0]   rle_run_i;
  logic [PIXEL_BIT-1:0] rle_level_i;
  logic                 rle_eob_i;
  logic                 rle_gecerli_i;
  logic                 rle_hazir_o;
  logic [PIXEL_BIT-1:0] zig_veri_o;
  logic [BLOCK_BIT-1:0] zig_veri_row_o;
  logic [BLOCK_BIT-1:0] zig_veri_col_o;
  logic                 zig_veri_gecerli_o;
  logic                 zig_veri_hazir_i;
  logic                 zig_blok_son_o;
  logic                 hata_o;

  always #5 clk_i = ~clk_i;

  zigzag_run_expander #(
    .PIXEL_BIT(PIXEL_BIT),
    .BLOCK_BIT(BLOCK_BIT),
    .RUN_BIT  (RUN_BIT)
  ) u_dut (
    .clk_i             (clk_i),
    .rstn_i            (rstn_i),
    .rle_run_i         (rle_run_i),
    .rle_level_i       (rle_level_i),
    .rle_eob_i         (rle_eob_i),
    .rle_gecerli_i     (rle_gecerli_i),
    .rle_hazir_o       (rle_hazir_o),
    .zig_veri_o        (zig_veri_o),
    .zig_veri_row_o    (zig_veri_row_o),
    .zig_veri_col_o    (zig_veri_col_o),
    .zig_veri_gecerli_o(zig_veri_gecerli_o),
    .zig_veri_hazir_i  (zig_veri_hazir_i),
    .zig_blok_son_o    (zig_blok_son_o),
    .hata_o            (hata_o)
  );

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [18:0] sb_q[$];
  int          zz_row[64];
  int          zz_col[64];
  int          m_idx  = 0;
  logic        m_hata = 1'b0;
  logic        ready_toggle = 1'b0;
  logic [18:0] held;
  logic        held_v = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  // Zigzag walk by anti-diagonals: even diagonals go up-right, odd go down-left.
  task automatic build_zz();
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 8) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz_row[k] = r; zz_col[k] = s - r; k++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz_row[k] = r; zz_col[k] = s - r; k++; end
      end
    end
  endtask

  function automatic logic [18:0] beat(input int idx, input int data);
    return {(idx == 63), 3'(zz_row[idx]), 3'(zz_col[idx]), 12'(data)};
  endfunction

  task automatic push_zeros_to_end();
    for (int i = m_idx; i < 64; i++) sb_q.push_back(beat(i, 0));
    m_idx = 0;
  endtask

  task automatic model_accept(input int run, input int lvl, input logic eob);
    if (eob) begin
      push_zeros_to_end();
    end else if (m_idx + run > 63) begin
      push_zeros_to_end();
      m_hata = 1'b1;
    end else begin
      for (int i = 0; i < run; i++) begin sb_q.push_back(beat(m_idx, 0)); m_idx++; end
      sb_q.push_back(beat(m_idx, lvl));
      m_idx = (m_idx + 1) % 64;
    end
  endtask

  // Present a token until the DUT takes it; the model sees it at acceptance.
  task automatic send(input int run, input int lvl, input logic eob);
    int   n     = 0;
    logic fired = 1'b0;
    rle_run_i     = RUN_BIT'(run);
    rle_level_i   = PIXEL_BIT'(lvl);
    rle_eob_i     = eob;
    rle_gecerli_i = 1'b1;
    while (!fired) begin
      @(negedge clk_i);
      if (rle_hazir_o) begin
        fired = 1'b1;
        model_accept(run, lvl, eob);
      end
      @(posedge clk_i); #1;
      n++;
      if (!fired && n > 300) begin
        check_val("token_timeout", {31'b0, rle_hazir_o}, 32'd1);
        break;
      end
    end
    rle_gecerli_i = 1'b0;
    rle_eob_i     = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (!(sb_q.size() == 0 && !zig_veri_gecerli_o)) begin
      @(posedge clk_i); #1;
      n++;
      if (n > 1000) begin
        check_val("drain_timeout", sb_q.size(), 32'd0);
        break;
      end
    end
  endtask

  // Downstream ready: constant high, or toggling every cycle.
  initial begin
    zig_veri_hazir_i = 1'b1;
    forever begin
      @(posedge clk_i); #1;
      zig_veri_hazir_i = ready_toggle ? ~zig_veri_hazir_i : 1'b1;
    end
  end

  // Output monitor: stall stability and scoreboard compare on each transfer.
  always @(negedge clk_i) begin
    logic [18:0] cur;
    logic [18:0] exp;
    cur = {zig_blok_son_o, zig_veri_row_o, zig_veri_col_o, zig_veri_o};
    if (rstn_i) begin
      if (held_v) check_val("stall_hold", {12'b0, zig_veri_gecerli_o, cur}, {12'b0, 1'b1, held});
      held_v = zig_veri_gecerli_o && !zig_veri_hazir_i;
      held   = cur;
      if (zig_veri_gecerli_o && zig_veri_hazir_i) begin
        if (sb_q.size() == 0) begin
          check_val("extra_beat", {31'b0, zig_veri_gecerli_o}, 32'd0);
        end else begin
          exp = sb_q.pop_front();
          check_val("beat", {13'b0, cur}, {13'b0, exp});
        end
      end
    end else begin
      held_v = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    build_zz();
    rstn_i        = 1'b0;
    rle_gecerli_i = 1'b0;
    rle_run_i     = '0;
    rle_level_i   = '0;
    rle_eob_i     = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check_val("rst_valid", {31'b0, zig_veri_gecerli_o}, 32'd0);
    check_val("rst_hazir", {31'b0, rle_hazir_o}, 32'd0);
    check_val("rst_hata",  {31'b0, hata_o}, 32'd0);
    check_val("rst_son",   {31'b0, zig_blok_son_o}, 32'd0);
    check_val("rst_data",  {20'b0, zig_veri_o}, 32'd0);
    rstn_i = 1'b1;
    @(negedge clk_i);
    check_val("hazir_after_rst", {31'b0, rle_hazir_o}, 32'd1);
    @(posedge clk_i); #1;

    // Single level then EOB: one-cycle latency, block padded to idx 63.
    send(0, 50, 1'b0);
    check_val("latency", {31'b0, zig_veri_gecerli_o}, 32'd1);
    send(0, 0, 1'b1);
    drain();
    check_val("hata_clean", {31'b0, hata_o}, {31'b0, m_hata});

    // Run of 2: upstream ready low while the zeros go out.
    send(2, -3, 1'b0);
    @(negedge clk_i);
    check_val("run_busy0", {31'b0, rle_hazir_o}, 32'd0);
    @(negedge clk_i);
    check_val("run_busy1", {31'b0, rle_hazir_o}, 32'd0);
    @(negedge clk_i);
    check_val("run_done", {31'b0, rle_hazir_o}, 32'd1);
    @(posedge clk_i); #1;
    send(0, 0, 1'b1);
    drain();

    // Full block of levels under a toggling downstream ready.
    ready_toggle = 1'b1;
    for (int k = 0; k < 64; k++) send(0, k, 1'b0);
    drain();
    ready_toggle = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;

    // Overflow at idx 60; the following token opens a new block.
    for (int k = 0; k < 60; k++) send(0, k + 1, 1'b0);
    send(5, 7, 1'b0);
    send(0, 33, 1'b0);
    send(0, 0, 1'b1);
    drain();
    check_val("hata_set", {31'b0, hata_o}, {31'b0, m_hata});

    // Reset in the middle of a long run.
    send(15, 9, 1'b0);
    repeat (3) @(posedge clk_i);
    #1;
    rstn_i = 1'b0;
    sb_q.delete();
    m_idx  = 0;
    m_hata = 1'b0;
    @(posedge clk_i); #1;
    check_val("midrst_valid", {31'b0, zig_veri_gecerli_o}, 32'd0);
    check_val("midrst_hazir", {31'b0, rle_hazir_o}, 32'd0);
    check_val("midrst_hata",  {31'b0, hata_o}, 32'd0);
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
    send(0, 5, 1'b0);
    send(0, 0, 1'b1);
    drain();

    // ZRL then a level at idx 16, then EOB.
    send(15, 0, 1'b0);
    send(0, 4, 1'b0);
    send(0, 0, 1'b1);
    drain();

    // EOB at idx 0 yields a whole block of zeros.
    send(0, 0, 1'b1);
    drain();
    check_val("hata_final", {31'b0, hata_o}, {31'b0, m_hata});
    check_val("sb_empty", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
